// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: FSM state enum, parameter defaults, wait-counter width.
package memory_arbiter_pkg;

    localparam int DEF_CHANNELS     = 2;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_READ_LATENCY = 1;

    // The wait counter runs 0..READ_LATENCY-1, and READ_LATENCY is at most 4.
    localparam int WAIT_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant for the first requester after last_grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant_o is all-zero when no request is present.
// Ports: req_i (request vector), last_grant_i (index of previous owner), grant_o (one-hot pick).
module round_robin_arbiter #(
    parameter int  CHANNELS = 2,
    localparam int IDX_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]    last_grant_i,
    output logic [CHANNELS-1:0] grant_o
);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        logic             found;
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        // Search order is last+1, last+2, ... wrapping, ending on last itself.
        for (int k = 1; k <= CHANNELS; k++) begin
            sum = {1'b0, last_grant_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(CHANNELS)) begin
                sum = sum - (IDX_W+1)'(CHANNELS);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port among CHANNELS requesters, one transaction at a time.
// Latency: write ready 2 cycles after request sampled in IDLE, read ready 2+READ_LATENCY cycles.
// Backpressure: requesters hold req_valid until their req_ready pulse; others wait in IDLE arbitration.
// Ports: clock/reset; req_* per-channel request bundle (slice i = channel i); req_ready/req_rdata
//        completion; mem_* memory port; grant one-hot owner; busy high outside IDLE.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int  CHANNELS     = DEF_CHANNELS,
    parameter int  ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int  DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int  READ_LATENCY = DEF_READ_LATENCY,
    localparam int STRB_W       = DATA_WIDTH / 8,
    localparam int IDX_W        = $clog2(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            req_valid,
    input  logic [CHANNELS-1:0]            req_write,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] req_address,
    input  logic [CHANNELS*DATA_WIDTH-1:0] req_wdata,
    input  logic [CHANNELS*STRB_W-1:0]     req_strobe,
    output logic [CHANNELS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]          req_rdata,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [STRB_W-1:0]              mem_strobe,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [CHANNELS-1:0]            grant,
    output logic                           busy
);

    arb_state_t                state_q, state_d;
    logic [CHANNELS-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic                      wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]         strb_q, strb_d;
    logic [WAIT_CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    logic [CHANNELS-1:0]       rr_grant;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_wr;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;
    logic [STRB_W-1:0]         sel_strb;

    round_robin_arbiter #(.CHANNELS(CHANNELS)) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (rr_grant)
    );

    // One-hot mux of the winning channel's request fields.
    always_comb begin
        sel_idx   = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rr_grant[i]) begin
                sel_idx   = IDX_W'(i);
                sel_wr    = req_write[i];
                sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strobe[i*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_grant;
                    last_d  = sel_idx;
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    strb_d  = sel_strb;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = wr_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // Capture on the edge that closes the last wait cycle.
                if (cnt_q == WAIT_CNT_W'(READ_LATENCY - 1)) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(CHANNELS - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign mem_read    = (state_q == ST_ISSUE) && !wr_q;
    assign mem_write   = (state_q == ST_ISSUE) &&  wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_strobe  = strb_q;
    assign grant       = grant_q;
    assign req_ready   = (state_q == ST_DONE) ? grant_q : '0;
    assign req_rdata   = rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int CH = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int RL = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [CH-1:0]     req_valid, req_write, req_ready, grant;
    logic [CH*AW-1:0]  req_address;
    logic [CH*DW-1:0]  req_wdata;
    logic [CH*SW-1:0]  req_strobe;
    logic [DW-1:0]     req_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_address;
    logic [SW-1:0]     mem_strobe;
    logic              mem_read, mem_write, busy;

    memory_arbiter #(
        .CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
        .req_wdata(req_wdata), .req_strobe(req_strobe), .req_ready(req_ready),
        .req_rdata(req_rdata), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_strobe(mem_strobe),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    int n;
    int checks = 0;
    int fails  = 0;

    // Transaction-level reference model: one owner, a start cycle and a ready cycle.
    bit            m_act;
    int            m_own, m_t0, m_rdy, m_last;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_strb;
    logic [CH-1:0] obs_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [CH-1:0] v, input int last);
        for (int k = 1; k <= CH; k++) begin
            if (v[(last + k) % CH]) return (last + k) % CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_act   = 1'b0;
        m_last  = CH - 1;
        m_rdata = '0;
    endtask

    task automatic compare();
        logic [CH-1:0] eg, er;
        bit iss;
        eg = '0; er = '0; iss = 1'b0;
        if (m_act) begin
            eg[m_own] = 1'b1;
            iss = (n == m_t0 + 1);
            if (n == m_rdy) er = eg;
        end
        obs_rdy = req_ready;
        chk("busy", busy, m_act);
        chk("grant", grant, eg);
        chk("req_ready", req_ready, er);
        chk("mem_read", mem_read, iss && !m_wr);
        chk("mem_write", mem_write, iss && m_wr);
        chk("req_rdata", req_rdata, m_rdata);
        if (iss) begin
            chk("mem_address", mem_address, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_strobe", mem_strobe, m_strb);
        end
    endtask

    task automatic model_step();
        if (m_act) begin
            if (!m_wr && n == m_t0 + 1 + RL) m_rdata = mem_rdata;
            if (n == m_rdy) m_act = 1'b0;
        end else if (req_valid != '0) begin
            m_own   = rr_pick(req_valid, m_last);
            m_last  = m_own;
            m_act   = 1'b1;
            m_t0    = n;
            m_wr    = req_write[m_own];
            m_addr  = req_address[m_own*AW +: AW];
            m_wdata = req_wdata[m_own*DW +: DW];
            m_strb  = req_strobe[m_own*SW +: SW];
            m_rdy   = n + (m_wr ? 2 : 2 + RL);
        end
    endtask

    // Compares cycle n at the falling edge, then returns 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clock);
        compare();
        model_step();
        @(posedge clock);
        #1;
        n++;
    endtask

    task automatic set_req(input int ch, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[ch]         = 1'b1;
        req_write[ch]         = wr;
        req_address[ch*AW +: AW] = a;
        req_wdata[ch*DW +: DW]   = d;
        req_strobe[ch*SW +: SW]  = s;
    endtask

    task automatic drain();
        int lim;
        lim = 0;
        req_valid = '0;
        tick();
        while (m_act && lim < 40) begin
            tick();
            lim++;
        end
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        logic [CH-1:0] rr_seq[$];
        logic [CH-1:0] rr_exp[4];
        rr_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        reset = 1'b0;
        req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0; req_strobe = '0;
        mem_rdata = '0;
        obs_rdy = '0;
        n = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rw", {mem_read, mem_write}, 2'b00);
        chk("rst_rdata", req_rdata, 32'h0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_strobe", mem_strobe, 4'h0);
        #1 reset = 1'b1;
        n = 0;

        // Two channels valid continuously from reset release: 0,1,0,1.
        set_req(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF);
        set_req(1, 1'b1, 32'h0000_0020, 32'h2222_2222, 4'hF);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (req_ready != '0) rr_seq.push_back(req_ready);
        end
        chk("rr_pulses", rr_seq.size(), 4);
        for (int i = 0; i < 4 && i < rr_seq.size(); i++) chk("rr_order", rr_seq[i], rr_exp[i]);
        drain();

        // Single write on channel 0.
        set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        tick();
        chk("wr_mem_write", mem_write, 1'b1);
        chk("wr_mem_read", mem_read, 1'b0);
        chk("wr_addr", mem_address, 32'h100);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_strobe", mem_strobe, 4'hF);
        tick();
        chk("wr_ready", req_ready, 4'b0001);
        req_valid[0] = 1'b0;
        tick();

        // Read on channel 1; memory returns DEADBEEF only on the last wait cycle.
        set_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
        mem_rdata = 32'h1111_1111;
        tick();
        chk("rd_mem_read", mem_read, 1'b1);
        chk("rd_addr", mem_address, 32'h100);
        tick(); tick(); tick();
        chk("rd_ready_early", req_ready, 4'b0000);
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rdata = 32'h2222_2222;
        chk("rd_rdata", req_rdata, 32'hDEADBEEF);
        chk("rd_ready", req_ready, 4'b0010);
        req_valid[1] = 1'b0;
        tick();

        // Last grant was 1; channels 1 and 3 request: 3 first, then 1.
        set_req(1, 1'b1, 32'h10, 32'hA1A1_A1A1, 4'h1);
        set_req(3, 1'b1, 32'h30, 32'hA3A3_A3A3, 4'h8);
        tick();
        chk("rr4_first", grant, 4'b1000);
        tick();
        chk("rr4_first_rdy", req_ready, 4'b1000);
        req_valid[3] = 1'b0;
        tick();
        tick();
        chk("rr4_second", grant, 4'b0010);
        chk("rr4_addr", mem_address, 32'h10);
        tick();
        chk("rr4_second_rdy", req_ready, 4'b0010);
        chk("rdata_hold", req_rdata, 32'hDEADBEEF);
        req_valid[1] = 1'b0;
        tick();

        // Requester drops valid and changes address during ISSUE.
        set_req(2, 1'b1, 32'h200, 32'hCAFEF00D, 4'h3);
        tick();
        req_valid[2] = 1'b0;
        req_address[2*AW +: AW] = 32'h3FC;
        req_wdata[2*DW +: DW] = 32'h0BAD_0BAD;
        chk("imm_addr", mem_address, 32'h200);
        chk("imm_wdata", mem_wdata, 32'hCAFEF00D);
        chk("imm_strobe", mem_strobe, 4'h3);
        tick();
        chk("imm_ready", req_ready, 4'b0100);
        tick();

        // Reset during WAIT of a channel 0 read.
        set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_grant", grant, 4'b0000);
        chk("arst_ready", req_ready, 4'b0000);
        chk("arst_rw", {mem_read, mem_write}, 2'b00);
        chk("arst_rdata", req_rdata, 32'h0);
        chk("arst_addr", mem_address, 32'h0);
        chk("arst_wdata", mem_wdata, 32'h0);
        chk("arst_strobe", mem_strobe, 4'h0);
        @(posedge clock);
        #1;
        chk("arst_ready_held", req_ready, 4'b0000);
        #1 reset = 1'b1;
        model_reset();
        n = 0;
        set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
        tick();
        chk("arst_next_grant", grant, 4'b0001);
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            tick();
            mem_rdata = $urandom;
            for (int ch = 0; ch < CH; ch++) begin
                if (obs_rdy[ch]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(ch, 1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom));
                    else
                        req_valid[ch] = 1'b0;
                end else if (!req_valid[ch]) begin
                    if ($urandom_range(2, 0) == 0)
                        set_req(ch, 1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom));
                end else if (m_act && m_own == ch) begin
                    set_req(ch, 1'($urandom_range(1, 0)), $urandom, $urandom, 4'($urandom));
                end
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
